// File: rtl/instr_exec_unit.sv
// instr_exec_unit: single-cycle fetch/execute stage with 4x8 register file, HALT/RESUME FSM and PC stall; CARRY_FLAG_EN enables the C flag
module instr_exec_unit (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] INSTR,
   input  logic       STALL,
   input  logic       RESUME,
   output logic       JMP,
   output logic [1:0] JMP_OFFSET,
   output logic [7:0] OUT_DATA,
   output logic       OUT_VALID,
   output logic       HALTED,
   output logic       FLAG_Z,
   output logic       FLAG_C
);
   typedef enum logic {RUN, HALT} state_t;
   state_t state, state_n;
   logic [7:0] r [4];
   logic [1:0] op, rd, rs, rt;
   logic [7:0] res, wd, od_n;
   logic       we, jmp_n, ov_n, z_n, c_ok, taken;
   logic [1:0] off_n;
   assign op = INSTR[7:6];
   assign rd = INSTR[5:4];
   assign rs = INSTR[3:2];
   assign rt = INSTR[1:0];
   assign HALTED = (state == HALT);
`ifdef CARRY_FLAG_EN
   logic c_q, c_n, carry;
   assign {carry, res} = {1'b0, r[rs]} + {1'b0, r[rt]};
   assign c_ok = c_q;
   assign FLAG_C = c_q;
`else
   assign res = r[rs] + r[rt];
   assign c_ok = 1'b0;
   assign FLAG_C = 1'b0;
`endif
   assign taken = (rd == 2'b00) | ((rd == 2'b01) & FLAG_Z) | ((rd == 2'b10) & c_ok);
   // next-state and next-output decode; HALT and STALL both hold the PC with offset 11
   always_comb begin
      state_n = state;
      jmp_n   = 1'b0;
      off_n   = 2'b00;
      ov_n    = 1'b0;
      od_n    = OUT_DATA;
      we      = 1'b0;
      wd      = 8'h00;
      z_n     = FLAG_Z;
`ifdef CARRY_FLAG_EN
      c_n     = c_q;
`endif
      if (state == HALT) begin
         state_n = RESUME ? RUN : HALT;
         jmp_n   = RESUME ? STALL : 1'b1;
         off_n   = RESUME ? {2{STALL}} : 2'b11;
      end else if (STALL) begin
         jmp_n = 1'b1;
         off_n = 2'b11;
      end else begin
         case (op)
            2'b00: begin
               we = 1'b1;
               wd = {4'b0, INSTR[3:0]};
            end
            2'b01: begin
               we  = 1'b1;
               wd  = res;
               z_n = (res == 8'h00);
`ifdef CARRY_FLAG_EN
               c_n = carry;
`endif
            end
            2'b10: begin
               ov_n = 1'b1;
               od_n = r[rt];
            end
            default: begin
               state_n = (rd == 2'b11) ? HALT : RUN;
               jmp_n   = (rd == 2'b11) | taken;
               off_n   = (rd == 2'b11) ? 2'b11 : (taken ? rt : 2'b00);
            end
         endcase
      end
   end
   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= RUN;
      else     state <= state_n;
   end
   // datapath and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 4; i++) r[i] <= 8'h00;
         JMP        <= 1'b0;
         JMP_OFFSET <= 2'b00;
         OUT_DATA   <= 8'h00;
         OUT_VALID  <= 1'b0;
         FLAG_Z     <= 1'b0;
`ifdef CARRY_FLAG_EN
         c_q        <= 1'b0;
`endif
      end else begin
         if (we) r[rd] <= wd;
         JMP        <= jmp_n;
         JMP_OFFSET <= off_n;
         OUT_DATA   <= od_n;
         OUT_VALID  <= ov_n;
         FLAG_Z     <= z_n;
`ifdef CARRY_FLAG_EN
         c_q        <= c_n;
`endif
      end
   end
endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: randomized and directed check of instr_exec_unit against a behavioural model with a PC and program memory
module tb_instr_exec_unit;
   logic clk = 0, rst = 1, stall = 0, resume = 0;
   logic [7:0] instr = 0;
   logic jmp, out_valid, halted, flag_z, flag_c;
   logic [1:0] jmp_offset;
   logic [7:0] out_data;
   int nvec = 0, nerr = 0;
   bit chk_en = 0;
   logic [7:0] mem [32];
   logic [4:0] pc;
   logic [7:0] m_r [4];
   logic m_z, m_c, m_h, m_j, m_ov;
   logic [1:0] m_off;
   logic [7:0] m_od;

   instr_exec_unit dut (
      .CLK(clk), .RST(rst), .INSTR(instr), .STALL(stall), .RESUME(resume),
      .JMP(jmp), .JMP_OFFSET(jmp_offset), .OUT_DATA(out_data), .OUT_VALID(out_valid),
      .HALTED(halted), .FLAG_Z(flag_z), .FLAG_C(flag_c)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_z = 0; m_c = 0; m_h = 0; m_j = 0; m_off = 0; m_od = 0; m_ov = 0;
   endtask

   task automatic model_step();
      int s;
      logic t;
      m_ov = 0;
      if (m_h) begin
         if (resume) begin
            m_h = 0; m_j = stall; m_off = stall ? 2'd3 : 2'd0;
         end else begin
            m_j = 1; m_off = 3;
         end
      end else if (stall) begin
         m_j = 1; m_off = 3;
      end else begin
         m_j = 0; m_off = 0;
         case (instr[7:6])
            2'd0: m_r[instr[5:4]] = {4'd0, instr[3:0]};
            2'd1: begin
               s = int'(m_r[instr[3:2]]) + int'(m_r[instr[1:0]]);
               m_r[instr[5:4]] = 8'(s % 256);
               m_z = (s % 256) == 0;
`ifdef CARRY_FLAG_EN
               m_c = s > 255;
`endif
            end
            2'd2: begin
               m_od = m_r[instr[1:0]]; m_ov = 1;
            end
            default: begin
               if (instr[5:4] == 3) begin
                  m_h = 1; m_j = 1; m_off = 3;
               end else begin
                  t = (instr[5:4] == 0) || (instr[5:4] == 1 && m_z) || (instr[5:4] == 2 && m_c);
                  m_j = t; m_off = t ? instr[1:0] : 2'd0;
               end
            end
         endcase
      end
   endtask

   task automatic pc_advance();
      if (!m_j || m_off == 0) pc = pc + 1;
      else if (m_off == 1) pc = pc + 2;
      else if (m_off == 2) pc = pc - 1;
   endtask

   task automatic cycle(input bit s, input bit rs);
      stall = s; resume = rs; instr = mem[pc];
      @(posedge clk);
      model_step();
      @(negedge clk);
      pc_advance();
   endtask

   task automatic do_reset();
      #1 rst = 1;
      model_reset();
      pc = 0;
      #1;
      chk("rst_jmp", {jmp, jmp_offset}, 0);
      chk("rst_out", {out_valid, out_data}, 0);
      chk("rst_flags", {halted, flag_z, flag_c}, 0);
      rst = 0;
      chk_en = 1;
   endtask

   always @(posedge clk) if (chk_en) begin
      #1;
      chk("jmp", jmp, m_j);
      chk("jmp_offset", jmp_offset, m_off);
      chk("out_data", out_data, m_od);
      chk("out_valid", out_valid, m_ov);
      chk("halted", halted, m_h);
      chk("flag_z", flag_z, m_z);
      chk("flag_c", flag_c, m_c);
   end

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
   endtask

   initial begin
      clear_mem();
      mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h76; mem[3] = 8'h83;
      mem[4] = 8'hF0; mem[5] = 8'h19; mem[6] = 8'h81;
      do_reset();
      repeat (4) cycle(0, 0);
      chk("p1_out_data", out_data, 8'h08);
      chk("p1_out_valid", out_valid, 1);
      chk("p1_z", flag_z, 0);
      chk("p1_pc", pc, 4);
      cycle(0, 0);
      repeat (10) begin
         cycle(0, 0);
         chk("halt_pc", pc, 4);
         chk("halt_halted", halted, 1);
         chk("halt_jmp", {jmp, jmp_offset}, 3'b111);
      end
      cycle(0, 1);
      chk("resume_pc", pc, 5);
      chk("resume_halted", halted, 0);
      chk("resume_jmp", jmp, 0);
      repeat (3) begin
         cycle(1, 0);
         chk("stall_pc", pc, 5);
         chk("stall_jmp", {jmp, jmp_offset}, 3'b111);
      end
      cycle(0, 0);
      chk("unstall_pc", pc, 6);
      cycle(0, 0);
      chk("stall_r1", out_data, 8'h09);
      chk("stall_r1_valid", out_valid, 1);
      do_reset();
      cycle(0, 0);
      chk("restart_pc", pc, 1);
      chk("restart_out", {out_valid, out_data}, 0);

      clear_mem();
      mem[0] = 8'h00; mem[1] = 8'h50; mem[2] = 8'hD1;
      do_reset();
      repeat (3) cycle(0, 0);
      chk("jz_jmp", {jmp, jmp_offset}, 3'b101);
      chk("jz_pc", pc, 4);
      chk("jz_z", flag_z, 1);

      clear_mem();
      mem[0] = 8'h1F; mem[1] = 8'h55; mem[2] = 8'h55; mem[3] = 8'h55; mem[4] = 8'h55;
      mem[5] = 8'h2F; mem[6] = 8'h56; mem[7] = 8'h21; mem[8] = 8'h76; mem[9] = 8'hE1;
      mem[10] = 8'h83;
      do_reset();
      repeat (9) cycle(0, 0);
      chk("carry_z", flag_z, 1);
`ifdef CARRY_FLAG_EN
      chk("carry_c", flag_c, 1);
      cycle(0, 0);
      chk("jc_jmp", jmp, 1);
      chk("jc_pc", pc, 11);
`else
      chk("carry_c", flag_c, 0);
      cycle(0, 0);
      chk("jc_jmp", jmp, 0);
      chk("jc_pc", pc, 10);
      cycle(0, 0);
      chk("wrap_r3", out_data, 8'h00);
`endif

      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      do_reset();
      repeat (3000) cycle($urandom_range(7) == 0, $urandom_range(3) == 0);
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      do_reset();
      repeat (3000) cycle($urandom_range(3) == 0, $urandom_range(1) == 0);

      chk_en = 0;
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
